video_rx_locator: RTL and testbench

- Receive-side counterpart of the raster position counters: consumes an incoming video stream (data-enable plus vertical sync) and recovers the pixel x/y coordinates.
- Measures the line width and frame height and checks them against the expected timing.
- Asserts lock once a clean frame has been seen.
- Sits between the pixel input pins/synchroniser and the downstream frame-buffer writer.

---
 rtl/video_rx_locator.sv | 164 ++++++++++++++++
 tb/tb_video_rx_locator.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_rx_locator.sv
// Recovers pixel x/y from an incoming DE + VSYNC stream, measures line width and
// frame height against expected timing, and reports lock after a clean frame.
module video_rx_locator #(
  parameter int NUM_X_BITS = 10,
  parameter int NUM_Y_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  de_in,
  input  logic                  vsync_in,
  input  logic [NUM_X_BITS-1:0] expect_width,
  input  logic [NUM_Y_BITS-1:0] expect_height,
  output logic [NUM_X_BITS-1:0] x_out,
  output logic [NUM_Y_BITS-1:0] y_out,
  output logic                  pixel_valid,
  output logic                  line_done,
  output logic                  frame_done,
  output logic [NUM_X_BITS-1:0] measured_width,
  output logic                  width_err,
  output logic                  height_err,
  output logic                  locked
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t                r_state, w_state_next;
  logic                  r_de_q, r_de_qq, r_vs_q, r_vs_qq;
  logic [NUM_X_BITS-1:0] r_x_cnt, w_x_cnt_next;
  logic [NUM_Y_BITS-1:0] r_y_cnt, w_y_cnt_next;
  logic [NUM_Y_BITS-1:0] r_y_out, w_y_out_next;
  logic                  r_frame_err, w_frame_err_next;
  logic                  r_pixel_valid, w_pixel_valid_next;
  logic                  r_line_done, w_line_done_next;
  logic                  r_frame_done, w_frame_done_next;
  logic [NUM_X_BITS-1:0] r_measured_width, w_measured_width_next;
  logic                  r_width_err, w_width_err_next;
  logic                  r_height_err, w_height_err_next;
  logic                  r_locked, w_locked_next;

  logic                  w_de_rise, w_vs_rise;
  logic [NUM_X_BITS-1:0] w_x_inc;
  logic [NUM_Y_BITS-1:0] w_y_inc;
  logic                  w_height_bad, w_width_bad;

  // Edges are taken between the first and second input registers, which gives
  // the one-cycle pixel-to-output latency.
  assign w_de_rise    = r_de_q & ~r_de_qq;
  assign w_vs_rise    = r_vs_q & ~r_vs_qq;
  assign w_x_inc      = (&r_x_cnt) ? r_x_cnt : r_x_cnt + 1'b1;
  assign w_y_inc      = (&r_y_cnt) ? r_y_cnt : r_y_cnt + 1'b1;
  assign w_height_bad = (r_y_cnt != expect_height);
  assign w_width_bad  = (w_x_inc != expect_width);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= SEARCH;
      r_de_q           <= 1'b0;
      r_de_qq          <= 1'b0;
      r_vs_q           <= 1'b0;
      r_vs_qq          <= 1'b0;
      r_x_cnt          <= '0;
      r_y_cnt          <= '0;
      r_y_out          <= '0;
      r_frame_err      <= 1'b0;
      r_pixel_valid    <= 1'b0;
      r_line_done      <= 1'b0;
      r_frame_done     <= 1'b0;
      r_measured_width <= '0;
      r_width_err      <= 1'b0;
      r_height_err     <= 1'b0;
      r_locked         <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_de_q           <= de_in;
      r_de_qq          <= r_de_q;
      r_vs_q           <= vsync_in;
      r_vs_qq          <= r_vs_q;
      r_x_cnt          <= w_x_cnt_next;
      r_y_cnt          <= w_y_cnt_next;
      r_y_out          <= w_y_out_next;
      r_frame_err      <= w_frame_err_next;
      r_pixel_valid    <= w_pixel_valid_next;
      r_line_done      <= w_line_done_next;
      r_frame_done     <= w_frame_done_next;
      r_measured_width <= w_measured_width_next;
      r_width_err      <= w_width_err_next;
      r_height_err     <= w_height_err_next;
      r_locked         <= w_locked_next;
    end
  end

  always_comb begin
    w_state_next          = r_state;
    w_x_cnt_next          = r_x_cnt;
    w_y_cnt_next          = r_y_cnt;
    w_y_out_next          = r_y_out;
    w_frame_err_next      = r_frame_err;
    w_pixel_valid_next    = 1'b0;
    w_line_done_next      = 1'b0;
    w_frame_done_next     = 1'b0;
    w_measured_width_next = r_measured_width;
    w_width_err_next      = 1'b0;
    w_height_err_next     = 1'b0;
    w_locked_next         = r_locked;

    case (r_state)
      SEARCH: begin
        if (w_vs_rise) begin
          w_state_next     = BLANK;
          w_y_cnt_next     = '0;
          w_frame_err_next = 1'b0;
        end
      end
      BLANK, ACTIVE: begin
        // A vsync rise wins over everything, aborting any line in progress.
        if (w_vs_rise) begin
          w_state_next      = BLANK;
          w_frame_done_next = 1'b1;
          w_height_err_next = w_height_bad;
          w_locked_next     = ~(r_frame_err | w_height_bad);
          w_y_cnt_next      = '0;
          w_frame_err_next  = 1'b0;
        end else if (r_state == BLANK) begin
          if (w_de_rise) begin
            w_state_next       = ACTIVE;
            w_x_cnt_next       = '0;
            w_y_out_next       = r_y_cnt;
            w_pixel_valid_next = 1'b1;
          end
        end else if (r_de_q) begin
          w_x_cnt_next       = w_x_inc;
          w_pixel_valid_next = 1'b1;
        end else begin
          // In ACTIVE a low sample is always the falling edge of the line.
          w_state_next          = BLANK;
          w_line_done_next      = 1'b1;
          w_measured_width_next = w_x_inc;
          w_width_err_next      = w_width_bad;
          w_y_cnt_next          = w_y_inc;
          if (w_width_bad) begin
            w_frame_err_next = 1'b1;
            w_locked_next    = 1'b0;
          end
        end
      end
      default: w_state_next = SEARCH;
    endcase
  end

  assign x_out          = r_x_cnt;
  assign y_out          = r_y_out;
  assign pixel_valid    = r_pixel_valid;
  assign line_done      = r_line_done;
  assign frame_done     = r_frame_done;
  assign measured_width = r_measured_width;
  assign width_err      = r_width_err;
  assign height_err     = r_height_err;
  assign locked         = r_locked;

endmodule

// File: tb/tb_video_rx_locator.sv
// Scoreboard bench for video_rx_locator: expected pixels, line and frame
// events are queued as the stream is driven and popped when the DUT reports them.
module tb_video_rx_locator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       de_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic [9:0] ew = 10'd4;
  logic [9:0] eh = 10'd3;
  logic [2:0] ew2 = 3'd7;
  logic [9:0] eh2 = 10'd3;

  logic [9:0] x_out, y_out, measured_width;
  logic       pixel_valid, line_done, frame_done, width_err, height_err, locked;
  logic [2:0] x_out2, measured_width2;
  logic [9:0] y_out2;
  logic       pixel_valid2, line_done2, frame_done2, width_err2, height_err2, locked2;

  always #5 clk = ~clk;

  video_rx_locator #(.NUM_X_BITS(10), .NUM_Y_BITS(10)) dut (
    .clk(clk), .rst(rst), .de_in(de_in), .vsync_in(vsync_in),
    .expect_width(ew), .expect_height(eh),
    .x_out(x_out), .y_out(y_out), .pixel_valid(pixel_valid),
    .line_done(line_done), .frame_done(frame_done),
    .measured_width(measured_width), .width_err(width_err),
    .height_err(height_err), .locked(locked)
  );

  video_rx_locator #(.NUM_X_BITS(3), .NUM_Y_BITS(10)) dut_sat (
    .clk(clk), .rst(rst), .de_in(de_in), .vsync_in(vsync_in),
    .expect_width(ew2), .expect_height(eh2),
    .x_out(x_out2), .y_out(y_out2), .pixel_valid(pixel_valid2),
    .line_done(line_done2), .frame_done(frame_done2),
    .measured_width(measured_width2), .width_err(width_err2),
    .height_err(height_err2), .locked(locked2)
  );

  typedef struct packed { logic [9:0] x; logic [9:0] y; } pix_t;
  typedef struct packed { logic [9:0] w; logic err; } line_t;
  typedef struct packed { logic herr; logic lock; } frame_t;

  pix_t   pix_q[$];
  line_t  line_q[$];
  frame_t frame_q[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit mon2_en = 1'b0;
  int cnt2 = 0;
  int lines2 = 0;

  // Stream-level model of what the sender intends
  int cur_y = 0;
  bit ferr = 1'b0;
  bit lock_m = 1'b0;

  pix_t   m_pix;
  line_t  m_line;
  frame_t m_frame;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pixel_valid) begin
        checks++;
        if (pix_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: got x=%0d y=%0d, want no pixel", x_out, y_out);
        end else begin
          m_pix = pix_q.pop_front();
          if (x_out !== m_pix.x || y_out !== m_pix.y) begin
            errors++;
            $display("FAIL pixel_xy: got x=%0d y=%0d, want x=%0d y=%0d", x_out, y_out, m_pix.x, m_pix.y);
          end
        end
      end
      if (line_done) begin
        checks++;
        if (line_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_line_done: got width=%0d, want no line_done", measured_width);
        end else begin
          m_line = line_q.pop_front();
          if (measured_width !== m_line.w || width_err !== m_line.err) begin
            errors++;
            $display("FAIL line_result: got width=%0d err=%0b, want width=%0d err=%0b",
                     measured_width, width_err, m_line.w, m_line.err);
          end else begin
            $display("line   width=%0d err=%0b locked=%0b", measured_width, width_err, locked);
          end
        end
        if (width_err) begin
          checks++;
          if (locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_drop_on_width_err: got locked=%0b, want 0", locked);
          end
        end
      end
      if (frame_done) begin
        checks++;
        if (frame_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame_done: got herr=%0b locked=%0b, want no frame_done", height_err, locked);
        end else begin
          m_frame = frame_q.pop_front();
          if (height_err !== m_frame.herr || locked !== m_frame.lock) begin
            errors++;
            $display("FAIL frame_result: got herr=%0b locked=%0b, want herr=%0b locked=%0b",
                     height_err, locked, m_frame.herr, m_frame.lock);
          end else begin
            $display("frame  herr=%0b locked=%0b", height_err, locked);
          end
        end
      end
      if ((width_err && !line_done) || (height_err && !frame_done)) begin
        checks++;
        errors++;
        $display("FAIL stray_err_pulse: got werr=%0b herr=%0b, want none without done", width_err, height_err);
      end
    end
  end

  always @(negedge clk) begin
    if (mon2_en) begin
      if (pixel_valid2) begin
        checks++;
        if (x_out2 !== 3'((cnt2 < 7) ? cnt2 : 7)) begin
          errors++;
          $display("FAIL sat_x: got x=%0d, want %0d", x_out2, (cnt2 < 7) ? cnt2 : 7);
        end
        cnt2++;
      end
      if (line_done2) begin
        checks++;
        lines2++;
        if (measured_width2 !== 3'd7 || width_err2 !== 1'b0) begin
          errors++;
          $display("FAIL sat_line: got width=%0d err=%0b, want width=7 err=0", measured_width2, width_err2);
        end else begin
          $display("line   (3-bit) width=%0d err=%0b", measured_width2, width_err2);
        end
      end
    end
  end

  task automatic drive(input logic de, input logic vs);
    @(posedge clk);
    #1;
    de_in    = de;
    vsync_in = vs;
  endtask

  task automatic send_line(input int n, input int gap, input bit chk_last);
    int y0;
    bit err;
    y0 = cur_y;
    for (int i = 0; i < n; i++) pix_q.push_back('{x: 10'(i), y: 10'(y0)});
    err = (10'(n) != ew);
    line_q.push_back('{w: 10'(n), err: err});
    if (err) begin
      ferr   = 1'b1;
      lock_m = 1'b0;
    end
    cur_y++;
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    if (chk_last) begin
      checks++;
      if (pixel_valid !== 1'b1 || x_out !== 10'(n - 2)) begin
        errors++;
        $display("FAIL latency_prev_pixel: got valid=%0b x=%0d, want valid=1 x=%0d", pixel_valid, x_out, n - 2);
      end
      @(posedge clk);
      #1;
      checks++;
      if (pixel_valid !== 1'b1 || x_out !== 10'(n - 1) || y_out !== 10'(y0)) begin
        errors++;
        $display("FAIL latency_last_pixel: got valid=%0b x=%0d y=%0d, want valid=1 x=%0d y=%0d",
                 pixel_valid, x_out, y_out, n - 1, y0);
      end
    end
    for (int g = 1; g < gap; g++) drive(1'b0, 1'b0);
  endtask

  task automatic send_vsync(input bit first);
    bit herr;
    if (!first) begin
      herr   = (10'(cur_y) != eh);
      lock_m = !(ferr || herr);
      frame_q.push_back('{herr: herr, lock: lock_m});
    end
    cur_y = 0;
    ferr  = 1'b0;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  task automatic drain(input string name);
    repeat (4) drive(1'b0, 1'b0);
    checks++;
    if (pix_q.size() + line_q.size() + frame_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_events: got pending pix=%0d line=%0d frame=%0d, want 0",
               name, pix_q.size(), line_q.size(), frame_q.size());
      pix_q.delete();
      line_q.delete();
      frame_q.delete();
    end
  endtask

  task automatic check_locked(input string name, input logic want);
    checks++;
    if (locked !== want) begin
      errors++;
      $display("FAIL %s_locked: got %0b, want %0b", name, locked, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checks++;
    if ({x_out, y_out, pixel_valid, line_done, frame_done, measured_width,
         width_err, height_err, locked} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got x=%0d y=%0d v=%0b ld=%0b fd=%0b mw=%0d we=%0b he=%0b lk=%0b, want all 0",
               x_out, y_out, pixel_valid, line_done, frame_done, measured_width, width_err, height_err, locked);
    end
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_lock();
    ew = 10'd4;
    eh = 10'd3;
    send_vsync(1'b1);
    send_line(4, 2, 1'b0);
    send_line(4, 2, 1'b0);
    send_line(4, 2, 1'b1);
    send_vsync(1'b0);
    drain("lock");
    check_locked("lock", 1'b1);
  endtask

  task automatic test_short_line();
    send_line(4, 2, 1'b0);
    send_line(3, 2, 1'b0);
    send_line(4, 2, 1'b0);
    send_vsync(1'b0);
    for (int i = 0; i < 3; i++) send_line(4, 2, 1'b0);
    send_vsync(1'b0);
    drain("short_line");
    check_locked("short_line_relock", 1'b1);
  endtask

  task automatic test_extra_line();
    for (int i = 0; i < 4; i++) send_line(4, 2, 1'b0);
    send_vsync(1'b0);
    drain("extra_line");
    check_locked("extra_line", 1'b0);
  endtask

  task automatic test_vsync_midline();
    bit herr;
    send_line(4, 2, 1'b0);
    pix_q.push_back('{x: 10'd0, y: 10'(cur_y)});
    herr   = (10'(cur_y) != eh);
    lock_m = !(ferr || herr);
    frame_q.push_back('{herr: herr, lock: lock_m});
    cur_y = 0;
    ferr  = 1'b0;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_line(4, 2, 1'b0);
    send_vsync(1'b0);
    drain("vsync_midline");
    check_locked("vsync_midline_relock", 1'b1);
  endtask

  task automatic test_saturation();
    cnt2    = 0;
    lines2  = 0;
    mon2_en = 1'b1;
    send_line(10, 2, 1'b0);
    drain("saturation");
    mon2_en = 1'b0;
    checks++;
    if (lines2 != 1 || cnt2 != 10 || x_out2 !== 3'd7 || measured_width2 !== 3'd7) begin
      errors++;
      $display("FAIL sat_summary: got lines=%0d pixels=%0d x=%0d mw=%0d, want lines=1 pixels=10 x=7 mw=7",
               lines2, cnt2, x_out2, measured_width2);
    end
    send_vsync(1'b0);
    drain("saturation_frame");
  endtask

  task automatic test_zero_expect();
    ew = 10'd0;
    eh = 10'd0;
    send_line(4, 2, 1'b0);
    send_line(4, 2, 1'b0);
    send_vsync(1'b0);
    drain("zero_expect");
    check_locked("zero_expect", 1'b0);
    ew = 10'd4;
    eh = 10'd3;
  endtask

  task automatic test_reset_midline();
    mon_en = 1'b0;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({x_out, y_out, pixel_valid, line_done, frame_done, measured_width,
         width_err, height_err, locked} !== '0) begin
      errors++;
      $display("FAIL midline_reset_outputs: got x=%0d y=%0d v=%0b ld=%0b lk=%0b, want all 0",
               x_out, y_out, pixel_valid, line_done, locked);
    end
    rst = 1'b0;
    pix_q.delete();
    line_q.delete();
    frame_q.delete();
    cur_y  = 0;
    ferr   = 1'b0;
    lock_m = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive((i % 3) != 2, 1'b0);
      checks++;
      if (pixel_valid !== 1'b0 || line_done !== 1'b0) begin
        errors++;
        $display("FAIL search_ignores_de: got valid=%0b line_done=%0b, want 0 0", pixel_valid, line_done);
      end
    end
    send_vsync(1'b1);
    for (int i = 0; i < 3; i++) send_line(4, 2, 1'b0);
    send_vsync(1'b0);
    drain("reset_midline");
    check_locked("reset_midline_relock", 1'b1);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_short_line();
    test_extra_line();
    test_vsync_midline();
    test_saturation();
    test_zero_expect();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
